// File: rtl/rf_multiport.sv
// Multiport register file: two combinational read ports with write-first bypass, one write port,
// a debug tap with constant offset, and a sequential clear engine that zeroes one entry per cycle.
module rf_multiport #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter bit          ZERO_R0 = 1'b1,
  parameter logic [31:0] DBG_OFS = 32'h20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          we,
  input  logic          clr,
  output logic          busy,
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_q
);

  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic {StIdle, StClear} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mem_q [Depth];
  logic          wr_en;

  assign busy  = (state_q == StClear);
  // Writes are dropped during a clear, during reset, and to a hardwired entry 0.
  assign wr_en = we && !busy && !rst && !(ZERO_R0 && (wa == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (busy) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        mem_q[wa] <= wd;
      end
    end
  end

  always_comb begin
    rd1 = mem_q[ra1];
    if (ZERO_R0 && (ra1 == '0)) begin
      rd1 = '0;
    end else if (wr_en && (ra1 == wa)) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (ZERO_R0 && (ra2 == '0)) begin
      rd2 = '0;
    end else if (wr_en && (ra2 == wa)) begin
      rd2 = wd;
    end
  end

  // Modulo 2**DW: the carry out of the add is simply dropped.
  assign dbg_q = mem_q[dbg_sel] + DW'(DBG_OFS);

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: directed scenarios plus random traffic checked against
// an array-based reference model of the register file and its clear sequence.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst, we, clr, busy;
  logic [4:0]  ra1, ra2, wa, dbg_sel;
  logic [31:0] rd1, rd2, wd, dbg_q;

  logic        z_rst, z_we, z_clr, z_busy;
  logic [4:0]  z_ra1, z_wa;
  logic [31:0] z_rd1, z_rd2, z_wd, z_dbg;

  logic [31:0] m [32];
  int          clr_left = 0;
  int          clr_idx  = 0;
  int          errors   = 0;
  int          checks   = 0;
  int          nb;

  always #5 clk = ~clk;

  rf_multiport u_dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .wa(wa), .wd(wd),
    .we(we), .clr(clr), .busy(busy), .dbg_sel(dbg_sel), .dbg_q(dbg_q)
  );

  rf_multiport #(.ZERO_R0(1'b0)) u_dut_z (
    .clk(clk), .rst(z_rst), .ra1(z_ra1), .ra2(z_ra1), .rd1(z_rd1), .rd2(z_rd2), .wa(z_wa),
    .wd(z_wd), .we(z_we), .clr(z_clr), .busy(z_busy), .dbg_sel(z_ra1), .dbg_q(z_dbg)
  );

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (clr_left == 0 && we && !rst && wa == a) return wd;
    return m[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("dbg_q", dbg_q, m[dbg_sel] + 32'h20);
    chk("busy", {31'd0, busy}, {31'd0, clr_left > 0});
  endtask

  // Advance the model by one clock edge using the inputs currently applied, then the DUT.
  task automatic cyc();
    if (rst) begin
      foreach (m[i]) m[i] = 32'd0;
      clr_left = 0;
    end else if (clr_left > 0) begin
      m[clr_idx] = 32'd0;
      clr_idx++;
      clr_left--;
    end else begin
      if (we && wa != 5'd0) m[wa] = wd;
      if (clr) begin
        clr_left = 32;
        clr_idx  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic scan_all(input bit expect_zero);
    we = 1'b0; clr = 1'b0; rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i); dbg_sel = 5'(i);
      #1;
      check_all();
      if (expect_zero) begin
        chk("zero_rd1", rd1, 32'd0);
        chk("zero_dbg", dbg_q, 32'h20);
      end
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; we = 1'b0; clr = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0; dbg_sel = '0;
    z_rst = 1'b1; z_we = 1'b0; z_clr = 1'b0; z_ra1 = '0; z_wa = '0; z_wd = '0;
    foreach (m[i]) m[i] = 32'hx;
    #2;
    cyc();
    rst = 1'b0; z_rst = 1'b0;
    ra1 = 5'd9; ra2 = 5'd30; dbg_sel = 5'd4;
    #1;
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_rd2", rd2, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dbg", dbg_q, 32'h20);
    check_all();

    // Basic write, readback and debug tap.
    we = 1'b1; wa = 5'd17; wd = 32'hDEADBEEF; ra1 = 5'd17; dbg_sel = 5'd17;
    #1; check_all();
    cyc();
    we = 1'b0;
    #1;
    chk("wr17_rd1", rd1, 32'hDEADBEEF);
    chk("wr17_dbg", dbg_q, 32'hDEADBF0F);

    // Same-cycle bypass on both ports.
    we = 1'b1; wa = 5'd5; wd = 32'h1234; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    chk("byp_rd1", rd1, 32'h1234);
    chk("byp_rd2", rd2, 32'h1234);
    check_all();
    cyc();
    we = 1'b0;

    // Entry 0: hardwired in the default instance, writable with ZERO_R0=0.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; dbg_sel = 5'd0;
    z_we = 1'b1; z_wa = 5'd0; z_wd = 32'hFFFFFFFF; z_ra1 = 5'd0;
    #1;
    chk("r0_during", rd1, 32'd0);
    cyc();
    we = 1'b0; z_we = 1'b0;
    #1;
    chk("r0_after", rd1, 32'd0);
    chk("r0_dbg", dbg_q, 32'h20);
    chk("z_r0_rd1", z_rd1, 32'hFFFFFFFF);
    chk("z_r0_rd2", z_rd2, 32'hFFFFFFFF);
    chk("z_r0_dbg", z_dbg, 32'h0000001F);
    chk("z_busy", {31'd0, z_busy}, 32'd0);

    // Debug offset wraps modulo 2**32.
    we = 1'b1; wa = 5'd3; wd = 32'hFFFFFFF0; dbg_sel = 5'd3;
    #1; check_all();
    cyc();
    we = 1'b0;
    #1;
    chk("dbg_wrap", dbg_q, 32'h00000010);

    // Fill, clear, count busy cycles while hammering with ignored writes and clr.
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i + 1); ra1 = 5'($urandom); ra2 = 5'(i);
      dbg_sel = 5'($urandom);
      #1; check_all();
      cyc();
    end
    we = 1'b0;
    clr = 1'b1;
    #1; check_all();
    cyc();
    clr = 1'b0;
    nb = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (!busy) break;
      nb++;
      we = 1'($urandom); wa = 5'($urandom); wd = $urandom; clr = 1'($urandom);
      ra1 = 5'($urandom); ra2 = 5'($urandom); dbg_sel = 5'($urandom);
      #1; check_all();
      cyc();
    end
    chk("busy_len", 32'(nb), 32'd32);
    scan_all(1'b1);

    // Reset in the middle of a clear, with clr asserted alongside it.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 5'($urandom); wd = $urandom;
      #1; check_all();
      cyc();
    end
    we = 1'b0; clr = 1'b1;
    #1; check_all();
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ra1 = 5'($urandom); ra2 = 5'($urandom); dbg_sel = 5'($urandom);
      #1; check_all();
      cyc();
    end
    rst = 1'b1; clr = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'h5555AAAA;
    #1; check_all();
    cyc();
    rst = 1'b0; clr = 1'b0; we = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    scan_all(1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom % 64) == 0;
      clr = ($urandom % 40) == 0;
      we = 1'($urandom);
      wa = 5'($urandom); wd = ($urandom % 4 == 0) ? 32'hFFFFFFFF - 32'($urandom % 64) : $urandom;
      ra1 = 5'($urandom); ra2 = ($urandom % 4 == 0) ? wa : 5'($urandom);
      dbg_sel = 5'($urandom);
      #1; check_all();
      cyc();
    end
    scan_all(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 Parameter DW, default 32, SHALL set the data width in bits of every entry.
REQ-002 Parameter AW, default 5, SHALL set the address width; depth SHALL be 2**AW entries.
REQ-003 Parameter ZERO_R0, default 1, SHALL hardwire entry 0 to zero when 1 and make it writable when 0.
REQ-004 Parameter DBG_OFS, default 32'h20, SHALL be the constant added to the debug tap value.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge only.
REQ-006 rst  in  1  reset; synchronous and active-high, sampled on rising clk.
REQ-007 ra1, ra2  in  AW  read addresses, ports 1 and 2.
REQ-008 rd1, rd2  out  DW  read data, ports 1 and 2, combinational from address and state.
REQ-009 wa  in  AW  write address.
REQ-010 wd  in  DW  write data.
REQ-011 we  in  1  write enable.
REQ-012 clr  in  1  start sequential clear, one-cycle pulse or level.
REQ-013 busy  out  1  high while a sequential clear is in progress.
REQ-014 dbg_sel  in  AW  debug tap entry select.
REQ-015 dbg_q  out  DW  debug tap: entry[dbg_sel] + DBG_OFS, truncated to DW bits.

Function
REQ-016 Write: when we=1, busy=0, rst=0 and not (ZERO_R0=1 and wa=0), entry[wa] SHALL take wd at the rising edge.
REQ-017 Read: rdN SHALL equal entry[raN] with zero added latency; with ZERO_R0=1 and raN=0, rdN SHALL be 0.
REQ-018 Bypass: when a write per REQ-016 is enabled in the current cycle and raN=wa, rdN SHALL equal wd (write-first).
REQ-019 Bypass SHALL NOT apply to address 0 when ZERO_R0=1, nor while busy=1.
REQ-020 Both read ports SHALL be independent; ra1=ra2 SHALL return identical data.
REQ-021 Clear FSM states: IDLE, CLEAR; reset state IDLE.
REQ-022 IDLE -> CLEAR when clr=1; AW-bit counter SHALL load 0; busy SHALL be 1 from the next cycle.
REQ-023 In CLEAR, each cycle SHALL zero entry[counter] and increment counter; after zeroing entry 2**AW-1, FSM SHALL return to IDLE.
REQ-024 A clear SHALL take exactly 2**AW cycles with busy=1; busy SHALL fall the cycle after the last entry is zeroed.
REQ-025 Counter wrap from 2**AW-1 to 0 SHALL coincide with the CLEAR->IDLE transition.
REQ-026 clr asserted while in CLEAR SHALL be ignored; the clear SHALL NOT restart.
REQ-027 we=1 while busy=1 SHALL be dropped silently; no entry SHALL change from the write.
REQ-028 While busy=1, rd1, rd2 and dbg_q SHALL reflect current stored contents (partially cleared).
REQ-029 we=1 and clr=1 in the same IDLE cycle: the write SHALL complete and the clear SHALL start; the written entry is subsequently zeroed.
REQ-030 Debug addition SHALL be modulo 2**DW; overflow carry SHALL be discarded.

Reset
REQ-031 rst=1 SHALL, in one clock edge, zero all entries, force FSM to IDLE, counter to 0, busy to 0.
REQ-032 rst SHALL take priority over we, clr and an in-progress clear.
REQ-033 After reset: rd1=rd2=0, busy=0, dbg_q=DBG_OFS.

Verification
REQ-034 Defaults; rst 1 cycle; write 32'hDEADBEEF to 17; dbg_sel=17 -> dbg_q=32'hDEADBF0F next cycle; ra1=17 -> rd1=32'hDEADBEEF.
REQ-035 we=1, wa=5, wd=32'h1234, ra1=ra2=5 same cycle -> rd1=rd2=32'h1234 before the edge (bypass).
REQ-036 ZERO_R0=1; write 32'hFFFFFFFF to 0, ra1=0 -> rd1=0 during and after; ZERO_R0=0 -> rd1=32'hFFFFFFFF after edge.
REQ-037 Fill all 32 entries with index+1; pulse clr -> busy high exactly 32 cycles; writes during busy ignored; afterward all entries 0.
REQ-038 rst asserted at cycle 10 of a clear -> next cycle busy=0, all entries 0, FSM IDLE; clr in same cycle as rst ignored.
REQ-039 Write 32'hFFFFFFF0 to 3, dbg_sel=3 -> dbg_q=32'h00000010 (wrap).
